// File: rtl/rst_req_gen.sv
// rst_req_gen: merges power-on, debounced push-button, CPU soft-reset and
// watchdog timeout into one stretched, registered, active-low system reset.
// The cause of the most recent reset is held for software readback.
//
// Ports:
//   clk_100m     : the only clock
//   rst_n        : board power-on reset, asynchronous, active low
//   key_n        : push-button, active low, asynchronous and bouncy
//   soft_rst_req : single-cycle soft-reset request from the CPU
//   wdt_en       : watchdog enable (level)
//   wdt_kick     : watchdog reload pulse
//   wdt_load     : watchdog reload value
//   sys_rst_n    : registered system reset, active low
//   rst_cause    : 0 = POR, 1 = key, 2 = soft, 3 = watchdog (sticky)
//   rst_busy     : high while the pulse or the hold-off window is running
module rst_req_gen #(
   parameter int unsigned PULSE_LEN = 16,
   parameter int unsigned HOLD_LEN  = 64,
   parameter int unsigned DEB_CYC   = 1_000_000,
   parameter int unsigned WDT_W     = 24
) (
   input  logic             clk_100m,
   input  logic             rst_n,
   input  logic             key_n,
   input  logic             soft_rst_req,
   input  logic             wdt_en,
   input  logic             wdt_kick,
   input  logic [WDT_W-1:0] wdt_load,
   output logic             sys_rst_n,
   output logic [1:0]       rst_cause,
   output logic             rst_busy
);

   localparam int unsigned CNT_MAX = (PULSE_LEN > HOLD_LEN) ? PULSE_LEN : HOLD_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned DEB_W   = $clog2(DEB_CYC);

   localparam logic [1:0] CAUSE_POR  = 2'd0;
   localparam logic [1:0] CAUSE_KEY  = 2'd1;
   localparam logic [1:0] CAUSE_SOFT = 2'd2;
   localparam logic [1:0] CAUSE_WDT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sys_rst_n_d;
   logic             rst_busy_d;
   logic [1:0]       rst_cause_d;

   logic             key_meta, key_s, key_deb, key_deb_q;
   logic [DEB_W-1:0] deb_cnt;
   logic             key_req;

   logic [WDT_W-1:0] wdt_cnt;
   logic             wdt_run;
   logic             wdt_req;

   logic             req_any;
   logic [1:0]       req_cause;

   // Key path: 2-FF synchronizer, then a run-length debouncer
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         key_meta  <= 1'b0;
         key_s     <= 1'b0;
         key_deb   <= 1'b0;
         key_deb_q <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         key_meta  <= ~key_n;
         key_s     <= key_meta;
         key_deb_q <= key_deb;
         if (key_s != key_deb) begin
            if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
               key_deb <= key_s;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Press edge is consumed every cycle, so a held key cannot retrigger
   assign key_req = key_deb & ~key_deb_q;

   // Watchdog only counts in IDLE; elsewhere it sits at the reload value
   assign wdt_run = (state_q == ST_IDLE) && wdt_en;
   assign wdt_req = wdt_run && !wdt_kick && (wdt_cnt == '0);

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt <= wdt_load;
      end else if (!wdt_run || wdt_kick) begin
         wdt_cnt <= wdt_load;
      end else if (wdt_cnt != '0) begin
         wdt_cnt <= wdt_cnt - WDT_W'(1);
      end
   end

   // Request merge, watchdog > soft > key
   assign req_any   = wdt_req | soft_rst_req | key_req;
   assign req_cause = wdt_req      ? CAUSE_WDT  :
                      soft_rst_req ? CAUSE_SOFT : CAUSE_KEY;

   // State and registered outputs
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         sys_rst_n <= 1'b0;
         rst_busy  <= 1'b1;
         rst_cause <= CAUSE_POR;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sys_rst_n <= sys_rst_n_d;
         rst_busy  <= rst_busy_d;
         rst_cause <= rst_cause_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sys_rst_n_d = sys_rst_n;
      rst_busy_d  = rst_busy;
      rst_cause_d = rst_cause;
      case (state_q)
         ST_IDLE: begin
            sys_rst_n_d = 1'b1;
            rst_busy_d  = 1'b0;
            if (req_any) begin
               state_d     = ST_ASSERT;
               cnt_d       = '0;
               sys_rst_n_d = 1'b0;
               rst_busy_d  = 1'b1;
               rst_cause_d = req_cause;
            end
         end
         ST_ASSERT: begin
            sys_rst_n_d = 1'b0;
            rst_busy_d  = 1'b1;
            if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
               state_d     = ST_HOLDOFF;
               cnt_d       = '0;
               sys_rst_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLDOFF: begin
            sys_rst_n_d = 1'b1;
            rst_busy_d  = 1'b1;
            if (cnt_q == CNT_W'(HOLD_LEN - 1)) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               rst_busy_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // Unused encoding: recover through a fresh pulse
            state_d     = ST_ASSERT;
            cnt_d       = '0;
            sys_rst_n_d = 1'b0;
            rst_busy_d  = 1'b1;
         end
      endcase
   end

endmodule
